// File: rtl/iommu_chk_pkg.sv
// rtl/iommu_chk_pkg.sv - error codes shared by the IOMMU shadow/protocol checkers
package iommu_chk_pkg;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      OVERFLOW  = 3'd1,
      UNDERFLOW = 3'd2,
      FULL_MM   = 3'd3,
      EMPTY_MM  = 3'd4,
      USAGE_MM  = 3'd5,
      DATA_MM   = 3'd6
   } err_code_e;

endpackage

// File: rtl/iommu_fifo_shadow_ch.sv
// rtl/iommu_fifo_shadow_ch.sv - one shadow FIFO channel: circular buffer, pointers and per-cycle checks
module iommu_fifo_shadow_ch
   import iommu_chk_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter bit FALL_THROUGH = 1'b0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic                  full_i,
   input  logic                  empty_i,
   input  logic [ADDR_DEPTH-1:0] usage_i,
   output logic                  err_o,
   output err_code_e             code_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic is_full, is_empty, bypass, do_push, do_pop;
   logic ovf, udf, full_mm, empty_mm, usage_mm, data_mm;

   function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
      return (p == LAST_PTR) ? '0 : p + ADDR_DEPTH'(1);
   endfunction

   assign is_full  = (count_q == DEPTH_C);
   assign is_empty = (count_q == '0);

   // Fall-through bypass hands wdata straight to the reader; the shadow holds nothing.
   assign bypass  = FALL_THROUGH & push_i & pop_i & is_empty;
   assign do_push = ~flush_i & ~bypass & push_i & (~is_full | pop_i);
   assign do_pop  = ~flush_i & ~bypass & pop_i & ~is_empty;

   assign ovf      = ~flush_i & push_i & is_full & ~pop_i;
   assign udf      = ~flush_i & pop_i & is_empty & ~(FALL_THROUGH & push_i);
   assign full_mm  = (full_i != is_full);
   assign empty_mm = (empty_i != is_empty);
   assign usage_mm = (usage_i != count_q[ADDR_DEPTH-1:0]);
   assign data_mm  = ~flush_i & pop_i &
                     ((~is_empty & (rdata_i != mem_q[rd_ptr_q])) |
                      (is_empty & FALL_THROUGH & push_i & (rdata_i != wdata_i)));

   assign err_o = ovf | udf | full_mm | empty_mm | usage_mm | data_mm;

   always_comb begin
      code_o = NONE;
      if (ovf)           code_o = OVERFLOW;
      else if (udf)      code_o = UNDERFLOW;
      else if (full_mm)  code_o = FULL_MM;
      else if (empty_mm) code_o = EMPTY_MM;
      else if (usage_mm) code_o = USAGE_MM;
      else if (data_mm)  code_o = DATA_MM;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Data storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/iommu_fifo_shadow_chk.sv
// rtl/iommu_fifo_shadow_chk.sv - multi-channel FIFO shadow checker with sticky errors, first-error capture and count
module iommu_fifo_shadow_chk
   import iommu_chk_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int DEPTH        = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int FALL_THROUGH = 0,
   parameter int CNT_WIDTH    = 16,
   parameter int ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic [N_CH-1:0]            flush_i,
   input  logic [N_CH-1:0]            push_i,
   input  logic [N_CH-1:0]            pop_i,
   input  logic [N_CH*DATA_WIDTH-1:0] wdata_i,
   input  logic [N_CH*DATA_WIDTH-1:0] rdata_i,
   input  logic [N_CH-1:0]            full_i,
   input  logic [N_CH-1:0]            empty_i,
   input  logic [N_CH*ADDR_DEPTH-1:0] usage_i,
   output logic [N_CH-1:0]            err_o,
   output logic                       err_valid_o,
   output logic [2:0]                 first_code_o,
   output logic [CH_W-1:0]            first_ch_o,
   output logic [CNT_WIDTH-1:0]       err_cnt_o
);

   logic [N_CH-1:0] ch_err;
   err_code_e       ch_code [N_CH];
   err_code_e       sel_code;
   logic [CH_W-1:0] sel_ch;
   logic            any_err;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      iommu_fifo_shadow_ch #(
         .DEPTH        (DEPTH),
         .FALL_THROUGH (FALL_THROUGH != 0),
         .DATA_WIDTH   (DATA_WIDTH),
         .ADDR_DEPTH   (ADDR_DEPTH)
      ) u_ch (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .flush_i (flush_i[c]),
         .push_i  (push_i[c]),
         .pop_i   (pop_i[c]),
         .wdata_i (wdata_i[c*DATA_WIDTH +: DATA_WIDTH]),
         .rdata_i (rdata_i[c*DATA_WIDTH +: DATA_WIDTH]),
         .full_i  (full_i[c]),
         .empty_i (empty_i[c]),
         .usage_i (usage_i[c*ADDR_DEPTH +: ADDR_DEPTH]),
         .err_o   (ch_err[c]),
         .code_o  (ch_code[c])
      );
   end

   assign any_err = |ch_err;

   // Walk high-to-low so the lowest erroring channel wins.
   always_comb begin
      sel_code = NONE;
      sel_ch   = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (ch_err[c]) begin
            sel_code = ch_code[c];
            sel_ch   = CH_W'(c);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_o        <= '0;
         err_valid_o  <= 1'b0;
         first_code_o <= NONE;
         first_ch_o   <= '0;
         err_cnt_o    <= '0;
      end else if (clr_i) begin
         err_o        <= '0;
         err_valid_o  <= 1'b0;
         first_code_o <= NONE;
         first_ch_o   <= '0;
         err_cnt_o    <= '0;
      end else begin
         err_o       <= err_o | ch_err;
         err_valid_o <= any_err;
         if (any_err && first_code_o == NONE) begin
            first_code_o <= sel_code;
            first_ch_o   <= sel_ch;
         end
         if (any_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_iommu_fifo_shadow_chk.sv
// tb/tb_iommu_fifo_shadow_chk.sv - directed scoreboard bench for the FIFO shadow checker
module tb_iommu_fifo_shadow_chk;

   localparam int N_CH = 4;
   localparam int DEPTH = 4;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam int CW = 16;

   localparam logic [2:0] C_NONE = 3'd0, C_OVF = 3'd1, C_UDF = 3'd2, C_FULL = 3'd3,
                          C_EMPTY = 3'd4, C_DATA = 3'd6;

   logic clk_i = 1'b0;
   logic rst_ni, clr_i;
   logic [N_CH-1:0] flush, push, pop, full, empty;
   logic [DW-1:0] wd [N_CH];
   logic [DW-1:0] rd [N_CH];
   logic [AW-1:0] us [N_CH];
   logic [N_CH*DW-1:0] wdata_bus, rdata_bus;
   logic [N_CH*AW-1:0] usage_bus;

   logic [N_CH-1:0] err, ft_err;
   logic            err_valid, ft_err_valid;
   logic [2:0]      first_code, ft_first_code;
   logic [1:0]      first_ch, ft_first_ch;
   logic [CW-1:0]   err_cnt, ft_err_cnt;

   for (genvar g = 0; g < N_CH; g++) begin : g_pack
      assign wdata_bus[g*DW +: DW] = wd[g];
      assign rdata_bus[g*DW +: DW] = rd[g];
      assign usage_bus[g*AW +: AW] = us[g];
   end

   always #5 clk_i = ~clk_i;

   iommu_fifo_shadow_chk #(.N_CH(N_CH), .DEPTH(DEPTH), .DATA_WIDTH(DW), .FALL_THROUGH(0), .CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush), .push_i(push), .pop_i(pop),
      .wdata_i(wdata_bus), .rdata_i(rdata_bus), .full_i(full), .empty_i(empty), .usage_i(usage_bus),
      .err_o(err), .err_valid_o(err_valid), .first_code_o(first_code), .first_ch_o(first_ch),
      .err_cnt_o(err_cnt));

   iommu_fifo_shadow_chk #(.N_CH(N_CH), .DEPTH(DEPTH), .DATA_WIDTH(DW), .FALL_THROUGH(1), .CNT_WIDTH(CW)) dut_ft (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush), .push_i(push), .pop_i(pop),
      .wdata_i(wdata_bus), .rdata_i(rdata_bus), .full_i(full), .empty_i(empty), .usage_i(usage_bus),
      .err_o(ft_err), .err_valid_o(ft_err_valid), .first_code_o(ft_first_code), .first_ch_o(ft_first_ch),
      .err_cnt_o(ft_err_cnt));

   typedef struct {
      string      tag;
      logic [3:0] err;
      logic       valid;
      logic [2:0] code;
      logic [1:0] ch;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_mis = 0;

   // Reference FIFO contents, following a correct FALL_THROUGH=0 DUT.
   logic [DW-1:0] m_mem [N_CH][DEPTH];
   int m_cnt [N_CH];
   int m_rp [N_CH];
   int m_wp [N_CH];

   task automatic check_one(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_mis++;
         $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp_v);
      end
   endtask

   task automatic pop_compare();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = sb.pop_front();
         check_one(e.tag, "err_o", 32'(err), 32'(e.err));
         check_one(e.tag, "err_valid_o", 32'(err_valid), 32'(e.valid));
         check_one(e.tag, "first_code_o", 32'(first_code), 32'(e.code));
         check_one(e.tag, "first_ch_o", 32'(first_ch), 32'(e.ch));
         check_one(e.tag, "err_cnt_o", 32'(err_cnt), 32'(e.cnt));
      end
   endtask

   task automatic push_exp(input string tag, input logic [3:0] e_err, input logic e_valid,
                           input logic [2:0] e_code, input logic [1:0] e_ch, input logic [15:0] e_cnt);
      exp_t e;
      e.tag = tag; e.err = e_err; e.valid = e_valid; e.code = e_code; e.ch = e_ch; e.cnt = e_cnt;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      clr_i = 1'b0;
      flush = '0;
      push  = '0;
      pop   = '0;
      for (int c = 0; c < N_CH; c++) wd[c] = '0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_cnt[c] = 0; m_rp[c] = 0; m_wp[c] = 0;
      end
   endtask

   task automatic drive_flags();
      for (int c = 0; c < N_CH; c++) begin
         full[c]  = (m_cnt[c] == DEPTH);
         empty[c] = (m_cnt[c] == 0);
         us[c]    = AW'(m_cnt[c] % DEPTH);
         rd[c]    = (m_cnt[c] != 0) ? m_mem[c][m_rp[c]] : '0;
      end
   endtask

   task automatic model_update();
      for (int c = 0; c < N_CH; c++) begin
         bit dp, dq;
         if (flush[c]) begin
            m_cnt[c] = 0; m_rp[c] = 0; m_wp[c] = 0;
         end else begin
            dp = push[c] && (m_cnt[c] < DEPTH || pop[c]);
            dq = pop[c] && (m_cnt[c] > 0);
            if (dp) begin
               m_mem[c][m_wp[c]] = wd[c];
               m_wp[c] = (m_wp[c] + 1) % DEPTH;
            end
            if (dq) m_rp[c] = (m_rp[c] + 1) % DEPTH;
            m_cnt[c] = m_cnt[c] + int'(dp) - int'(dq);
         end
      end
   endtask

   task automatic cycle(input string tag, input logic [3:0] e_err, input logic e_valid,
                        input logic [2:0] e_code, input logic [1:0] e_ch, input logic [15:0] e_cnt);
      push_exp(tag, e_err, e_valid, e_code, e_ch, e_cnt);
      @(posedge clk_i);
      #1;
      pop_compare();
      model_update();
      idle_inputs();
      drive_flags();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0;
      idle_inputs();
      model_reset();
      drive_flags();
      repeat (2) @(posedge clk_i);
      #1;
      push_exp("reset", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      pop_compare();
      rst_ni = 1'b1;
      cycle("idle", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < N_CH; c++) begin
            push[c] = 1'b1;
            wd[c] = 32'hA000_0000 | 32'(c << 8) | 32'(k);
         end
         cycle("fill", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      end
      for (int k = 0; k < 4; k++) begin
         pop = '1;
         cycle("drain", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      end

      push[2] = 1'b1; wd[2] = 32'hBEEF;
      cycle("beef_push", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      pop[2] = 1'b1; rd[2] = 32'hDEAD;
      cycle("data_mm", 4'b0100, 1'b1, C_DATA, 2'd2, 16'd1);
      cycle("data_sticky", 4'b0100, 1'b0, C_DATA, 2'd2, 16'd1);
      clr_i = 1'b1;
      cycle("clr1", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      for (int k = 0; k < 4; k++) begin
         push[1] = 1'b1; wd[1] = 32'h1100 + 32'(k);
         cycle("ovf_fill", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      end
      push[1] = 1'b1; wd[1] = 32'h9999;
      cycle("overflow", 4'b0010, 1'b1, C_OVF, 2'd1, 16'd1);
      for (int k = 0; k < 4; k++) begin
         pop[1] = 1'b1;
         cycle("ovf_drain", 4'b0010, 1'b0, C_OVF, 2'd1, 16'd1);
      end
      clr_i = 1'b1;
      cycle("clr2", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      push[3] = 1'b1; pop[3] = 1'b1; wd[3] = 32'h55; rd[3] = 32'h55;
      cycle("ft_off", 4'b1000, 1'b1, C_UDF, 2'd3, 16'd1);
      check_one("ft_on", "err_o", 32'(ft_err), 32'd0);
      check_one("ft_on", "err_valid_o", 32'(ft_err_valid), 32'd0);
      check_one("ft_on", "first_code_o", 32'(ft_first_code), 32'(C_NONE));
      check_one("ft_on", "err_cnt_o", 32'(ft_err_cnt), 32'd0);
      pop[3] = 1'b1;
      cycle("ft_off_drain", 4'b1000, 1'b0, C_UDF, 2'd3, 16'd1);
      clr_i = 1'b1;
      cycle("clr3", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      empty[0] = 1'b0; us[3] = 2'd1;
      cycle("dual", 4'b1001, 1'b1, C_EMPTY, 2'd0, 16'd1);
      clr_i = 1'b1; empty[1] = 1'b0;
      cycle("clr_discard", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      cycle("after_clr", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      for (int k = 0; k < 3; k++) begin
         push[0] = 1'b1; wd[0] = 32'h300 + 32'(k);
         cycle("pre_flush", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      end
      flush[0] = 1'b1; push[0] = 1'b1; wd[0] = 32'h77;
      cycle("flush", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      cycle("post_flush", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      full[2] = 1'b1;
      cycle("full_mm1", 4'b0100, 1'b1, C_FULL, 2'd2, 16'd1);
      full[2] = 1'b1;
      cycle("full_mm2", 4'b0100, 1'b1, C_FULL, 2'd2, 16'd2);
      empty[1] = 1'b0;
      cycle("keep_first", 4'b0110, 1'b1, C_FULL, 2'd2, 16'd3);

      for (int c = 0; c < N_CH; c++) begin
         push[c] = 1'b1; wd[c] = 32'hCC00 + 32'(c);
      end
      #3 rst_ni = 1'b0;
      #1;
      push_exp("async_reset", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);
      pop_compare();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      model_reset();
      idle_inputs();
      drive_flags();
      cycle("post_reset", 4'b0, 1'b0, C_NONE, 2'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
